// File: rtl/fmul_pipe.sv
// fmul_pipe: pipelined IEEE-754-style multiplier with round-to-nearest-even, flush-to-zero
// underflow, valid/ready handshake on both sides and a pass-through tag.
module fmul_pipe #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] x1,
  input  logic [EXP_W+MAN_W:0] x2,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] y,
  output logic                 ovf,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int FW = 1 + EW + 2 + MAN_W + 2;
  localparam int RW = W + 1;
  localparam logic [EW-1:0] BIAS  = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic [EW-1:0] ONE_E = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [EW-1:0] MAX_E = {2'b00, {EXP_W{1'b1}}};

  // Front half: sign, biased exponent, special-input flags and the normalised
  // significand reduced to mantissa/guard/sticky. Exponent is two's complement in EW bits.
  function automatic logic [FW-1:0] mul_front(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [EXP_W-1:0]   ea;
    logic [EXP_W-1:0]   eb;
    logic [MAN_W:0]     ma;
    logic [MAN_W:0]     mb;
    logic [2*MAN_W+1:0] prod;
    logic [2*MAN_W:0]   frac;
    logic [EW-1:0]      e;
    logic               zero;
    logic               inf;
    ea   = a[W-2 -: EXP_W];
    eb   = b[W-2 -: EXP_W];
    ma   = {1'b1, a[MAN_W-1:0]};
    mb   = {1'b1, b[MAN_W-1:0]};
    prod = {{(MAN_W+1){1'b0}}, ma} * {{(MAN_W+1){1'b0}}, mb};
    e    = {2'b00, ea} + {2'b00, eb} - BIAS;
    if (prod[2*MAN_W+1]) begin
      frac = prod[2*MAN_W:0];
      e    = e + ONE_E;
    end else begin
      frac = {prod[2*MAN_W-1:0], 1'b0};
    end
    zero = (ea == '0) || (eb == '0);
    inf  = (&ea) || (&eb);
    return {a[W-1] ^ b[W-1], e, zero, inf, frac[2*MAN_W -: MAN_W], frac[MAN_W], |frac[MAN_W-1:0]};
  endfunction

  // Back half: RNE rounding, carry renormalisation, then specials/overflow/flush; returns {ovf, y}.
  function automatic logic [RW-1:0] mul_back(input logic [FW-1:0] f);
    logic             s;
    logic [EW-1:0]    e;
    logic             zero;
    logic             inf;
    logic [MAN_W-1:0] man;
    logic             guard;
    logic             sticky;
    logic [MAN_W:0]   rnd;
    logic [RW-1:0]    r;
    {s, e, zero, inf, man, guard, sticky} = f;
    rnd = {1'b0, man} + {{MAN_W{1'b0}}, guard & (sticky | man[0])};
    if (rnd[MAN_W]) begin
      e = e + ONE_E;
    end else begin
      e = e;
    end
    if (zero) begin
      r = {1'b0, s, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    end else if (inf) begin
      r = {1'b0, s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (!e[EW-1] && (e >= MAX_E)) begin
      r = {1'b1, s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (e[EW-1] || (e == '0)) begin
      r = {1'b0, s, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    end else begin
      r = {1'b0, s, e[EXP_W-1:0], rnd[MAN_W-1:0]};
    end
    return r;
  endfunction

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] ready_s;
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [TAG_W-1:0]  tag_d [STAGES];
  logic [RW-1:0]     out_res_s;

  // A slot can load when it is empty or its occupant moves on; the chain runs back from out_ready.
  always_comb begin
    ready_s = '0;
    ready_s[STAGES-1] = !v_q[STAGES-1] || out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      ready_s[i] = !v_q[i] || ready_s[i+1];
    end
  end

  // Valid bits and tags shift forward wherever the receiving slot is ready.
  always_comb begin
    v_d   = v_q;
    tag_d = tag_q;
    if (ready_s[0]) begin
      v_d[0] = in_valid;
      if (in_valid) begin
        tag_d[0] = in_tag;
      end else begin
        tag_d[0] = tag_q[0];
      end
    end else begin
      v_d[0] = v_q[0];
    end
    for (int i = 1; i < STAGES; i++) begin
      if (ready_s[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) begin
          tag_d[i] = tag_q[i-1];
        end else begin
          tag_d[i] = tag_q[i];
        end
      end else begin
        v_d[i] = v_q[i];
      end
    end
  end

  // Control and tag registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      v_q   <= v_d;
      tag_q <= tag_d;
    end
  end

  generate
    if (STAGES == 1) begin : g_one
      logic [RW-1:0] res_q;
      logic [RW-1:0] res_d;

      // Single slot: the whole multiply happens in front of the only register.
      always_comb begin
        if (ready_s[0] && in_valid) begin
          res_d = mul_back(mul_front(x1, x2));
        end else begin
          res_d = res_q;
        end
      end

      // Result register.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          res_q <= '0;
        end else begin
          res_q <= res_d;
        end
      end

      assign out_res_s = res_q;
    end else begin : g_multi
      localparam int NR = STAGES - 1;
      logic [FW-1:0] fr_q;
      logic [FW-1:0] fr_d;
      logic [RW-1:0] res_q [NR];
      logic [RW-1:0] res_d [NR];

      // Slot 0 keeps the unrounded product; rounding sits between slot 0 and slot 1.
      always_comb begin
        res_d = res_q;
        if (ready_s[0] && in_valid) begin
          fr_d = mul_front(x1, x2);
        end else begin
          fr_d = fr_q;
        end
        if (ready_s[1] && v_q[0]) begin
          res_d[0] = mul_back(fr_q);
        end else begin
          res_d[0] = res_q[0];
        end
        for (int k = 1; k < NR; k++) begin
          if (ready_s[k+1] && v_q[k]) begin
            res_d[k] = res_q[k-1];
          end else begin
            res_d[k] = res_q[k];
          end
        end
      end

      // Data registers; cleared on reset so y/ovf read zero.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          fr_q <= '0;
          for (int k = 0; k < NR; k++) begin
            res_q[k] <= '0;
          end
        end else begin
          fr_q  <= fr_d;
          res_q <= res_d;
        end
      end

      assign out_res_s = res_q[NR-1];
    end
  endgenerate

  assign in_ready  = ready_s[0];
  assign out_valid = v_q[STAGES-1];
  assign y         = out_res_s[W-1:0];
  assign ovf       = out_res_s[W];
  assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_fmul_pipe.sv
// Scoreboard bench for fmul_pipe (binary32 configuration): directed corner cases,
// backpressure, mid-stream reset and a randomised sweep against a real-arithmetic reference.
module tb_fmul_pipe;
  localparam int STAGES = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1;
  logic [31:0] x2;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        ovf;
  logic [3:0]  out_tag;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        rand_bp  = 1'b0;
  logic [36:0] exp_q [$];

  fmul_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(STAGES), .TAG_W(4)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .ovf(ovf), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: exact product in double precision, then rounded to binary32 by hand.
  function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          e;
    real         p;
    logic [63:0] db;
    logic [23:0] m;
    logic        g;
    logic        st;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {1'b0, s, 31'd0};
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {1'b0, s, 8'hFF, 23'd0};
    p  = (1.0 + real'(int'(a[22:0])) / 8388608.0) * (1.0 + real'(int'(b[22:0])) / 8388608.0);
    db = $realtobits(p);
    e  = int'(db[62:52]) - 1023 + int'(a[30:23]) + int'(b[30:23]) - 127;
    m  = {1'b0, db[51:29]};
    g  = db[28];
    st = |db[27:0];
    if (g && (st || m[0])) m = m + 24'd1;
    if (m[23]) e = e + 1;
    if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
    if (e <= 0) return {1'b0, s, 31'd0};
    return {1'b0, s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r[31]    = 1'($urandom_range(0, 1));
    r[30:23] = 8'($urandom_range(1, 254));
    r[22:0]  = 23'($urandom);
    return r;
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                      input logic [32:0] e);
    int n;
    n = 0;
    in_valid = 1'b1;
    x1 = a;
    x2 = b;
    in_tag = t;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    exp_q.push_back({t, e});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor: pops the oldest expectation on every output transfer.
  always begin
    logic [36:0] ent;
    @(negedge clk);
    #2;
    if (rstn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 64'(out_valid), 64'd0);
      end else begin
        ent = exp_q.pop_front();
        chk("y", 64'(y), 64'(ent[31:0]));
        chk("ovf", 64'(ovf), 64'(ent[32]));
        chk("tag", 64'(out_tag), 64'(ent[36:33]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int k;
    logic [31:0] a;
    logic [31:0] b;
    rstn = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x1 = 32'd0;
    x2 = 32'd0;
    in_tag = 4'd0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rstn = 1'b1;
    out_ready = 1'b1;

    // Latency of a single operation.
    send(32'h3F800000, 32'h3F800000, 4'h5, {1'b0, 32'h3F800000});
    lat = 1;
    #1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(STAGES));
    drain();

    // Directed arithmetic corners, back to back.
    send(32'h3F800001, 32'h3F800001, 4'h1, {1'b0, 32'h3F800002});
    send(32'h3F800001, 32'h3FC00000, 4'h2, {1'b0, 32'h3FC00002});
    send(32'h7F000000, 32'h40000000, 4'h3, {1'b1, 32'h7F800000});
    send(32'h7F7FFFFF, 32'h3F800001, 4'h4, {1'b1, 32'h7F800000});
    send(32'h80800000, 32'h3F000000, 4'h6, {1'b0, 32'h80000000});
    send(32'h00000000, 32'h7F800000, 4'h7, {1'b0, 32'h00000000});
    send(32'h7F800000, 32'hC0000000, 4'h8, {1'b0, 32'hFF800000});
    send(32'hC0000000, 32'h40400000, 4'h9, {1'b0, 32'hC0C00000});
    drain();

    // Backpressure: stall the output and offer six operations.
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      if (k < 6) begin
        a = rand_op();
        b = rand_op();
        in_valid = 1'b1;
        x1 = a;
        x2 = b;
        in_tag = 4'(k + 10);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back({4'(k + 10), ref_mul(a, b)});
        k++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    chk("bp_accepted", 64'(k), 64'(STAGES));
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_hold_valid", 64'(out_valid), 64'd1);
    chk("bp_hold_y", 64'(y), 64'(exp_q[0][31:0]));
    out_ready = 1'b1;
    for (int c = 0; c < STAGES; c++) begin
      chk("bp_stream_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
      #1;
    end
    while (k < 6) begin
      a = rand_op();
      b = rand_op();
      send(a, b, 4'(k + 10), ref_mul(a, b));
      if (k == 3) repeat (3) @(negedge clk);
      k++;
    end
    drain();

    // Mid-stream asynchronous reset.
    out_ready = 1'b0;
    a = rand_op();
    b = rand_op();
    send(a, b, 4'hA, ref_mul(a, b));
    in_valid = 1'b1;
    x1 = rand_op();
    x2 = rand_op();
    in_tag = 4'hB;
    repeat (STAGES) @(negedge clk);
    #1;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_y", 64'(y), 64'd0);
    chk("async_rst_ovf", 64'(ovf), 64'd0);
    chk("async_rst_tag", 64'(out_tag), 64'd0);
    exp_q.delete();
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("post_rst_idle", 64'(out_valid), 64'd0);
    end

    // Randomised sweep with random backpressure.
    @(negedge clk);
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = rand_op();
      b = rand_op();
      send(a, b, 4'($urandom_range(0, 15)), ref_mul(a, b));
    end
    rand_bp = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
